// File: rtl/isram_pkg.sv
// Shared definitions for the instruction SRAM responder: FSM states, limits
// and the per-byte even-parity helper used when ISRAM_PARITY_EN is defined.
package isram_pkg;

  localparam int unsigned WAIT_CYCLES_MAX    = 32'd7;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 32'd12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } isram_state_e;

  // One even-parity bit per byte: the bit equals the XOR of that byte.
  function automatic logic [7:0] byte_parity(input logic [63:0] data);
    logic [7:0] par;
    for (int b = 0; b < 8; b++) begin
      par[b] = ^data[8*b +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/isram_array.sv
// Synchronous single-port 64-bit storage with byte write enables.
// With ISRAM_PARITY_EN defined, a parity bit per byte is stored and read back.
module isram_array
  import isram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [63:0]           wdata,
  input  logic [7:0]            wstrb,
  output logic [63:0]           rdata
`ifdef ISRAM_PARITY_EN
  ,
  output logic [7:0]            rpar
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [63:0] mem_r [DEPTH];
  logic [63:0] rdata_r;

  // Data storage: byte-masked write, read data register updates only on re.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

`ifdef ISRAM_PARITY_EN
  logic [7:0] par_mem_r [DEPTH];
  logic [7:0] rpar_r;
  logic [7:0] wpar_s;

  assign wpar_s = byte_parity(wdata);

  // Parity storage tracks the data array byte for byte.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wstrb[b]) begin
          par_mem_r[addr][b] <= wpar_s[b];
        end
      end
    end
    if (re) begin
      rpar_r <= par_mem_r[addr];
    end
  end

  assign rpar = rpar_r;
`endif

endmodule

// File: rtl/isram_resp.sv
// Instruction SRAM responder: fetch read port with wait states, loader write port.
// Define ISRAM_PARITY_EN to add per-byte parity checking on reads.
module isram_resp
  import isram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 32'd0
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        isram_cs,
  input  logic [28:0] isram_adr,
  output logic [63:0] instr_fromsram,
  output logic        isram_stall,
  output logic        isram_err,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [28:0] ld_addr,
  input  logic [63:0] ld_wdata,
  input  logic [7:0]  ld_wstrb
);

  localparam logic [0:0]  ST_IDLE   = IDLE;
  localparam logic [0:0]  ST_WAIT   = WAIT;
  localparam logic [28:0] BASE_IDX  = BASE_ADDR[31:3];
  localparam logic [2:0]  WAIT_LAST = (WAIT_CYCLES > 32'd0) ? 3'(WAIT_CYCLES - 32'd1) : 3'd0;

  logic [0:0]            state_r;
  logic [2:0]            cnt_r;
  logic                  resp_pend_r;
  logic                  oor_pend_r;
  logic [28:0]           rd_idx_s;
  logic [28:0]           wr_idx_s;
  logic                  rd_in_range_s;
  logic                  wr_in_range_s;
  logic                  rd_accept_s;
  logic                  wr_en_s;
  logic [DEPTH_LOG2-1:0] arr_addr_s;
  logic [63:0]           arr_rdata_s;
  logic                  par_err_s;

  // Unsigned subtraction makes addresses below the base wrap to huge indices.
  assign rd_idx_s      = isram_adr - BASE_IDX;
  assign wr_idx_s      = ld_addr - BASE_IDX;
  assign rd_in_range_s = (rd_idx_s >> DEPTH_LOG2) == 29'd0;
  assign wr_in_range_s = (wr_idx_s >> DEPTH_LOG2) == 29'd0;

  assign rd_accept_s = (state_r == ST_IDLE) && isram_cs;
  assign ld_ready    = (state_r == ST_IDLE) && !isram_cs && !cpurst;
  assign wr_en_s     = ld_valid && ld_ready && wr_in_range_s;
  assign isram_stall = (state_r == ST_WAIT);

  // Single array port: a fetch read excludes a loader write in the same cycle.
  always_comb begin
    arr_addr_s = wr_idx_s[DEPTH_LOG2-1:0];
    if (rd_accept_s) begin
      arr_addr_s = rd_idx_s[DEPTH_LOG2-1:0];
    end else begin
      arr_addr_s = wr_idx_s[DEPTH_LOG2-1:0];
    end
  end

`ifdef ISRAM_PARITY_EN
  logic [7:0] arr_rpar_s;

  isram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .re    (rd_accept_s),
    .we    (wr_en_s),
    .addr  (arr_addr_s),
    .wdata (ld_wdata),
    .wstrb (ld_wstrb),
    .rdata (arr_rdata_s),
    .rpar  (arr_rpar_s)
  );

  assign par_err_s = |(byte_parity(arr_rdata_s) ^ arr_rpar_s);
`else
  isram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .re    (rd_accept_s),
    .we    (wr_en_s),
    .addr  (arr_addr_s),
    .wdata (ld_wdata),
    .wstrb (ld_wstrb),
    .rdata (arr_rdata_s)
  );

  assign par_err_s = 1'b0;
`endif

  // Read sequencing: resp_pend_r marks the edge on which the response is registered.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      resp_pend_r <= 1'b0;
      oor_pend_r  <= 1'b0;
    end else begin
      resp_pend_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rd_accept_s) begin
            oor_pend_r <= !rd_in_range_s;
            if (WAIT_CYCLES == 32'd0) begin
              resp_pend_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LAST;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r     <= ST_IDLE;
            resp_pend_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

  // Response register: data holds between responses, error is a one-cycle flag.
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      instr_fromsram <= 64'h0;
      isram_err      <= 1'b0;
    end else if (resp_pend_r) begin
      instr_fromsram <= oor_pend_r ? 64'h0 : arr_rdata_s;
      isram_err      <= oor_pend_r || par_err_s;
    end else begin
      isram_err      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isram_resp.sv
// Scoreboard bench for isram_resp: three instances (0, 3 and 5 wait states) share
// the address/loader buses; expected responses are queued and checked by a monitor.
module tb_isram_resp;

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  cs_v;
  logic [2:0]  ldv_v;
  logic [28:0] adr;
  logic [28:0] ld_addr;
  logic [63:0] ld_wdata;
  logic [7:0]  ld_wstrb;
  logic [63:0] d0, d1, d2;
  logic        s0, s1, s2;
  logic        e0, e1, e2;
  logic        r0, r1, r2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          inst;
    int          due;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] last_d [3];

  isram_resp #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .cpurst(rst_v[0]), .isram_cs(cs_v[0]), .isram_adr(adr),
    .instr_fromsram(d0), .isram_stall(s0), .isram_err(e0),
    .ld_valid(ldv_v[0]), .ld_ready(r0), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb));

  isram_resp #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(3)) u_d1 (
    .clk(clk), .cpurst(rst_v[1]), .isram_cs(cs_v[1]), .isram_adr(adr),
    .instr_fromsram(d1), .isram_stall(s1), .isram_err(e1),
    .ld_valid(ldv_v[1]), .ld_ready(r1), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb));

  isram_resp #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(5)) u_d2 (
    .clk(clk), .cpurst(rst_v[2]), .isram_cs(cs_v[2]), .isram_adr(adr),
    .instr_fromsram(d2), .isram_stall(s2), .isram_err(e2),
    .ld_valid(ldv_v[2]), .ld_ready(r2), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wk(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  function automatic logic [63:0] get_data(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  function automatic logic get_err(input int k);
    case (k)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  function automatic logic get_stall(input int k);
    case (k)
      0:       return s0;
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  function automatic logic get_rdy(input int k);
    case (k)
      0:       return r0;
      1:       return r1;
      default: return r2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input int due, input logic [63:0] d, input logic e);
    exp_t x;
    x.inst = k;
    x.due  = due;
    x.data = d;
    x.err  = e;
    sbq.push_back(x);
  endtask

  // Monitor: every response due at this edge is compared against the DUT outputs.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missed inst%0d due=%0d now=%0d", mon_e.inst, mon_e.due, cyc);
      end else begin
        chk($sformatf("resp_data_i%0d", mon_e.inst), get_data(mon_e.inst), mon_e.data);
        chk($sformatf("resp_err_i%0d", mon_e.inst), 64'(get_err(mon_e.inst)), 64'(mon_e.err));
      end
    end
  end

  task automatic load(input logic [28:0] a, input logic [63:0] d, input logic [7:0] s,
                      input logic [2:0] mask);
    ld_addr  = a;
    ld_wdata = d;
    ld_wstrb = s;
    ldv_v    = mask;
    tick();
    ldv_v    = 3'b000;
  endtask

  task automatic rd(input int k, input logic [28:0] a, input logic [63:0] d, input logic e);
    int w;
    int k0;
    w = wk(k);
    cs_v[k] = 1'b1;
    adr     = a;
    tick();
    k0      = cyc;
    cs_v[k] = 1'b0;
    for (int i = 1; i <= w; i++) push(k, k0 + i, last_d[k], 1'b0);
    push(k, k0 + 1 + w, d, e);
    last_d[k] = d;
    if (w == 0) begin
      chk("stall_w0", 64'(get_stall(k)), 64'd0);
    end else begin
      adr = ~a;
      for (int i = 0; i < w; i++) begin
        chk($sformatf("stall_hi_i%0d", k), 64'(get_stall(k)), 64'd1);
        tick();
      end
      chk($sformatf("stall_lo_i%0d", k), 64'(get_stall(k)), 64'd0);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sbq.size() > 0; t++) tick();
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic idle_hold(input int k, input int n);
    drain();
    for (int i = 0; i < n; i++) begin
      push(k, cyc + 1, last_d[k], 1'b0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_v    = 3'b111;
    cs_v     = 3'b000;
    ldv_v    = 3'b000;
    adr      = 29'h0;
    ld_addr  = 29'h0;
    ld_wdata = 64'h0;
    ld_wstrb = 8'h00;
    for (int k = 0; k < 3; k++) last_d[k] = 64'h0;
    repeat (3) tick();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_data_i%0d", k), get_data(k), 64'h0);
      chk($sformatf("rst_stall_i%0d", k), 64'(get_stall(k)), 64'd0);
      chk($sformatf("rst_err_i%0d", k), 64'(get_err(k)), 64'd0);
      chk($sformatf("rst_rdy_i%0d", k), 64'(get_rdy(k)), 64'd0);
    end

    rst_v = 3'b000;
    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("rdy_idle_i%0d", k), 64'(get_rdy(k)), 64'd1);

    load(29'h2000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 3'b111);
    load(29'h2001, 64'h1122_3344_5566_7788, 8'hFF, 3'b111);
    load(29'h2FFF, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 3'b111);
    load(29'h2004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b111);
    load(29'h3000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 3'b111);
    load(29'h1FFF, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 3'b111);

    // zero wait states: back-to-back reads, range edges, dropped writes
    rd(0, 29'h2001, 64'h1122_3344_5566_7788, 1'b0);
    rd(0, 29'h2FFF, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    rd(0, 29'h3000, 64'h0, 1'b1);
    rd(0, 29'h2000, 64'hDEAD_BEEF_0000_0001, 1'b0);
    rd(0, 29'h1FFF, 64'h0, 1'b1);
    rd(0, 29'h2FFF, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    idle_hold(0, 2);

    load(29'h2005, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b001);
    rd(0, 29'h2005, 64'h0123_4567_89AB_CDEF, 1'b0);

    // loader blocked while fetch holds cs, then a low-half strobed write
    cs_v[0]  = 1'b1;
    adr      = 29'h2001;
    ldv_v    = 3'b001;
    ld_addr  = 29'h2004;
    ld_wdata = 64'h0000_0000_1234_5678;
    ld_wstrb = 8'h0F;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rdy_blocked", 64'(r0), 64'd0);
      tick();
      push(0, cyc + 1, 64'h1122_3344_5566_7788, 1'b0);
    end
    last_d[0] = 64'h1122_3344_5566_7788;
    cs_v[0] = 1'b0;
    #1;
    chk("rdy_released", 64'(r0), 64'd1);
    tick();
    ldv_v = 3'b000;
    rd(0, 29'h2004, 64'hFFFF_FFFF_1234_5678, 1'b0);
    idle_hold(0, 1);

    // three wait states: stall length, address change ignored, range error
    rd(1, 29'h2001, 64'h1122_3344_5566_7788, 1'b0);
    rd(1, 29'h3000, 64'h0, 1'b1);
    rd(1, 29'h2FFF, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    idle_hold(1, 2);

    // five wait states: reset in the middle of a wait discards the read
    rd(2, 29'h2001, 64'h1122_3344_5566_7788, 1'b0);
    drain();
    cs_v[2] = 1'b1;
    adr     = 29'h2FFF;
    tick();
    cs_v[2] = 1'b0;
    tick();
    chk("stall_before_rst", 64'(s2), 64'd1);
    rst_v[2] = 1'b1;
    #1;
    chk("midrst_data", d2, 64'h0);
    chk("midrst_stall", 64'(s2), 64'd0);
    chk("midrst_err", 64'(e2), 64'd0);
    chk("midrst_rdy", 64'(r2), 64'd0);
    tick();
    rst_v[2]  = 1'b0;
    last_d[2] = 64'h0;
    #1;
    chk("postrst_stall", 64'(s2), 64'd0);
    chk("postrst_rdy", 64'(r2), 64'd1);
    idle_hold(2, 6);
    rd(2, 29'h2FFF, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
    drain();

`ifdef ISRAM_PARITY_EN
    u_d0.u_array.mem_r[1] = u_d0.u_array.mem_r[1] ^ 64'h0000_0000_0000_0020;
    rd(0, 29'h2001, 64'h1122_3344_5566_77A8, 1'b1);
    drain();
`endif

    idle_hold(0, 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
